// File: rtl/sseg_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sseg_score_ctrl
// Description : PONG score keeper and 4-digit common-anode display scanner.
//               Holds both players' scores, detects game over, and
//               time-multiplexes a single shared sseg_conv by driving its
//               3-bit point code together with the active-low anodes.
//               Optional build macro: SSEG_LAST_POINT_DP_EN lights the
//               decimal point on the digit of the player who scored last.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_score_ctrl #(
    parameter logic [15:0] REFRESH_DIV = 16'd50000, // pclk cycles per digit (>=2)
    parameter int          WIN_SCORE   = 3,         // score that ends the game (1..3)
    parameter int          FLASH_SCANS = 64         // scans per half-period of winner flash (>=1)
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       point_l,
    input  logic       point_r,
    input  logic       new_game,
    output logic [2:0] point_code,
    output logic [3:0] an,
    output logic       dp,
    output logic [1:0] score_l,
    output logic [1:0] score_r,
    output logic       game_over
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]  c_st_play    = 1'b0;
    localparam logic [0:0]  c_st_over    = 1'b1;

    localparam logic [15:0] c_presc_last = REFRESH_DIV - 16'd1;
    localparam int          c_fw         = (FLASH_SCANS > 1) ? $clog2(FLASH_SCANS) : 1;
    localparam logic [c_fw-1:0] c_flash_last = c_fw'(FLASH_SCANS - 1);
    localparam logic [1:0]  c_win        = 2'(WIN_SCORE);

    localparam logic [2:0]  c_code_p     = 3'd4;   // "P" glyph for the winner
    localparam logic [2:0]  c_code_sep   = 3'd7;   // separator glyph
    localparam logic [1:0]  c_dig_l      = 2'd3;   // leftmost digit carries left score
    localparam logic [1:0]  c_dig_r      = 2'd0;   // rightmost digit carries right score
    localparam logic [1:0]  c_score_max  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [15:0]     r_presc;
    logic [1:0]      r_idx;
    logic [c_fw-1:0] r_fcnt;
    logic            r_fphase;      // 1 = winner digit visible
    logic [0:0]      r_state;
    logic [1:0]      r_score_l;
    logic [1:0]      r_score_r;
    logic [1:0]      r_win;         // [1] left won, [0] right won
    logic [3:0]      r_an;
    logic [2:0]      r_pc;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic       w_presc_wrap;
    logic       w_scan_wrap;
    logic       w_play;
    logic       w_over;
    logic       w_acc_l;
    logic       w_acc_r;
    logic [1:0] w_inc_l;
    logic [1:0] w_inc_r;
    logic       w_win_l;
    logic       w_win_r;
    logic       w_enter_over;
    logic       w_blank;
    logic [3:0] w_an_nxt;
    logic [2:0] w_pc_nxt;

    assign w_presc_wrap = (r_presc == c_presc_last);
    assign w_scan_wrap  = w_presc_wrap && (r_idx == 2'd3);
    assign w_play       = (r_state == c_st_play);
    assign w_over       = (r_state == c_st_over);

    // new_game wins over points; left wins over a simultaneous right point
    assign w_acc_l      = w_play && point_l && !new_game;
    assign w_acc_r      = w_play && point_r && !point_l && !new_game;

    // Saturating increments; saturation cannot be hit with WIN_SCORE <= 3
    // but keeps a 3 from wrapping to 0 under any parameterisation.
    assign w_inc_l      = (r_score_l == c_score_max) ? c_score_max : r_score_l + 2'd1;
    assign w_inc_r      = (r_score_r == c_score_max) ? c_score_max : r_score_r + 2'd1;

    assign w_win_l      = w_acc_l && (w_inc_l == c_win);
    assign w_win_r      = w_acc_r && (w_inc_r == c_win);
    assign w_enter_over = w_win_l || w_win_r;

    // Winner's digit goes dark during the off half of the flash
    assign w_blank = w_over && !r_fphase &&
                     (((r_idx == c_dig_l) && r_win[1]) ||
                      ((r_idx == c_dig_r) && r_win[0]));

    // Anode drive: one-cold on the current digit unless it is blanked
    assign w_an_nxt = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);

    // Point code selection for the current digit
    always_comb begin
        w_pc_nxt = c_code_sep;
        case (r_idx)
            c_dig_l: w_pc_nxt = (w_over && r_win[1]) ? c_code_p : {1'b0, r_score_l};
            c_dig_r: w_pc_nxt = (w_over && r_win[0]) ? c_code_p : {1'b0, r_score_r};
            default: w_pc_nxt = c_code_sep;
        endcase
    end

    // ------------------------------------------------------------------------
    // Refresh prescaler: one wrap per digit slot
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 16'd0;
        end else if (w_presc_wrap) begin
            r_presc <= 16'd0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // Digit index advances once per prescaler wrap, rolling 3 -> 0
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
        end else if (w_presc_wrap) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Flash timing: count full scans, toggle phase every FLASH_SCANS scans;
    // restart in the visible phase whenever the game ends
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt   <= '0;
            r_fphase <= 1'b1;
        end else if (w_enter_over) begin
            r_fcnt   <= '0;
            r_fphase <= 1'b1;
        end else if (w_scan_wrap) begin
            if (r_fcnt == c_flash_last) begin
                r_fcnt   <= '0;
                r_fphase <= ~r_fphase;
            end else begin
                r_fcnt   <= r_fcnt + c_fw'(1);
            end
        end
    end

    // Game state machine with scores and winner latch
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_play;
            r_score_l <= 2'd0;
            r_score_r <= 2'd0;
            r_win     <= 2'b00;
        end else if (new_game) begin
            r_state   <= c_st_play;
            r_score_l <= 2'd0;
            r_score_r <= 2'd0;
            r_win     <= 2'b00;
        end else if (w_acc_l) begin
            r_score_l <= w_inc_l;
            if (w_win_l) begin
                r_state <= c_st_over;
                r_win   <= 2'b10;
            end
        end else if (w_acc_r) begin
            r_score_r <= w_inc_r;
            if (w_win_r) begin
                r_state <= c_st_over;
                r_win   <= 2'b01;
            end
        end
    end

    // Anodes and point code registered together so they never skew
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_an <= 4'b1111;
            r_pc <= 3'b111;
        end else begin
            r_an <= w_an_nxt;
            r_pc <= w_pc_nxt;
        end
    end

`ifdef SSEG_LAST_POINT_DP_EN
    logic [1:0] r_last;             // [1] left scored last, [0] right scored last
    logic       r_dp;
    logic       w_dp_nxt;

    assign w_dp_nxt = !( !w_blank &&
                         (((r_idx == c_dig_l) && r_last[1]) ||
                          ((r_idx == c_dig_r) && r_last[0])) );

    // Remember which player took the most recent accepted point
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 2'b00;
        end else if (new_game) begin
            r_last <= 2'b00;
        end else if (w_acc_l) begin
            r_last <= 2'b10;
        end else if (w_acc_r) begin
            r_last <= 2'b01;
        end
    end

    // Decimal point registered alongside the anodes
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp <= 1'b1;
        end else begin
            r_dp <= w_dp_nxt;
        end
    end

    assign dp = r_dp;
`else
    assign dp = 1'b1;
`endif

    assign an         = r_an;
    assign point_code = r_pc;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign game_over  = w_over;

endmodule
`default_nettype wire

// File: tb/tb_sseg_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_score_ctrl
// Description : Directed self-checking bench for sseg_score_ctrl with a
//               short refresh period (4) and short flash period (2 scans).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_score_ctrl;

    logic       pclk;
    logic       rst_n;
    logic       point_l;
    logic       point_r;
    logic       new_game;
    logic [2:0] point_code;
    logic [3:0] an;
    logic       dp;
    logic [1:0] score_l;
    logic [1:0] score_r;
    logic       game_over;

    int checks   = 0;
    int failures = 0;

    sseg_score_ctrl #(
        .REFRESH_DIV (16'd4),
        .WIN_SCORE   (3),
        .FLASH_SCANS (2)
    ) u_dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .point_l    (point_l),
        .point_r    (point_r),
        .new_game   (new_game),
        .point_code (point_code),
        .an         (an),
        .dp         (dp),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Advance at least one cycle, then until an matches v (bounded)
    task automatic wait_an(input logic [3:0] v, input string tag);
        int n;
        n = 0;
        tick();
        while (an !== v && n < 64) begin
            tick();
            n++;
        end
        chk(tag, {28'd0, an}, {28'd0, v});
    endtask

    task automatic pulse(input logic l, input logic r, input logic ng);
        point_l  = l;
        point_r  = r;
        new_game = ng;
        tick();
        point_l  = 1'b0;
        point_r  = 1'b0;
        new_game = 1'b0;
    endtask

    logic [3:0] exp_an [4];
    logic [2:0] exp_pc [4];
    int cnt_on, cnt_off, cnt_r;

    initial begin
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
        exp_pc[0] = 3'd0;    exp_pc[1] = 3'd7;    exp_pc[2] = 3'd7;    exp_pc[3] = 3'd0;

        rst_n = 1'b0; point_l = 1'b0; point_r = 1'b0; new_game = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        // ---- reset values
        chk("rst_an",    {28'd0, an},         32'hF);
        chk("rst_pc",    {29'd0, point_code}, 32'h7);
        chk("rst_dp",    {31'd0, dp},         32'h1);
        chk("rst_sl",    {30'd0, score_l},    32'h0);
        chk("rst_sr",    {30'd0, score_r},    32'h0);
        chk("rst_go",    {31'd0, game_over},  32'h0);
        rst_n = 1'b1;
        chk("first_cyc_an", {28'd0, an}, 32'hF);

        // ---- scan sequence: 4 cycles per digit, right to left
        tick();
        for (int k = 0; k < 16; k++) begin
            chk("scan_an", {28'd0, an},         {28'd0, exp_an[k/4]});
            chk("scan_pc", {29'd0, point_code}, {29'd0, exp_pc[k/4]});
            if (k < 15) tick();
        end

        // ---- left wins with three points
        pulse(1'b1, 1'b0, 1'b0);
        chk("sl_1", {30'd0, score_l}, 32'd1);
        repeat (9) tick();
        pulse(1'b1, 1'b0, 1'b0);
        chk("sl_2", {30'd0, score_l}, 32'd2);
        chk("go_still0", {31'd0, game_over}, 32'd0);
        repeat (9) tick();
        pulse(1'b1, 1'b0, 1'b0);
        chk("sl_3", {30'd0, score_l}, 32'd3);
        chk("go_set", {31'd0, game_over}, 32'd1);
        wait_an(4'b0111, "wait_dig3");
        chk("winner_P", {29'd0, point_code}, 32'd4);
        wait_an(4'b1110, "wait_dig0_over");
        chk("loser_score", {29'd0, point_code}, 32'd0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("over_ignore_r", {30'd0, score_r}, 32'd0);
        chk("over_hold", {31'd0, game_over}, 32'd1);

        // ---- flash: 2 scans visible, 2 scans blank, digit 0 unaffected
        wait_an(4'b1111, "wait_blank");
        cnt_on = 0; cnt_off = 0; cnt_r = 0;
        for (int k = 0; k < 128; k++) begin
            if (an == 4'b0111) cnt_on++;
            if (an == 4'b1111) cnt_off++;
            if (an[0] == 1'b0) cnt_r++;
            tick();
        end
        chk("flash_on_cycles",  cnt_on,  32'd16);
        chk("flash_off_cycles", cnt_off, 32'd16);
        chk("flash_dig0_cycles", cnt_r,  32'd32);

        // ---- new game, then simultaneous points from 1-1
        pulse(1'b0, 1'b0, 1'b1);
        chk("ng_sl", {30'd0, score_l}, 32'd0);
        chk("ng_go", {31'd0, game_over}, 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("one_one", {28'd0, score_l, score_r}, 32'h5);
        pulse(1'b1, 1'b1, 1'b0);
        chk("simul_sl", {30'd0, score_l}, 32'd2);
        chk("simul_sr", {30'd0, score_r}, 32'd1);
        wait_an(4'b1110, "wait_dig0_21");
        chk("dig0_shows_r", {29'd0, point_code}, 32'd1);
        wait_an(4'b0111, "wait_dig3_21");
        chk("dig3_shows_l", {29'd0, point_code}, 32'd2);

        // ---- new_game coincident with point_r at 2-2
        pulse(1'b0, 1'b1, 1'b0);
        chk("two_two", {28'd0, score_l, score_r}, 32'hA);
        chk("two_two_go", {31'd0, game_over}, 32'd0);
        pulse(1'b0, 1'b1, 1'b1);
        chk("ngp_scores", {28'd0, score_l, score_r}, 32'h0);
        chk("ngp_go", {31'd0, game_over}, 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("play_after_ng", {30'd0, score_l}, 32'd1);
        pulse(1'b0, 1'b0, 1'b1);

        // ---- right wins, then asynchronous reset mid-scan
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        pulse(1'b0, 1'b1, 1'b0);
        chk("r_win_go", {31'd0, game_over}, 32'd1);
        chk("r_win_sr", {30'd0, score_r}, 32'd3);
        wait_an(4'b1110, "wait_dig0_rwin");
        chk("r_winner_P", {29'd0, point_code}, 32'd4);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", {28'd0, an},         32'hF);
        chk("async_pc", {29'd0, point_code}, 32'h7);
        chk("async_dp", {31'd0, dp},         32'h1);
        chk("async_sc", {28'd0, score_l, score_r}, 32'h0);
        chk("async_go", {31'd0, game_over},  32'h0);
        tick();
        rst_n = 1'b1;
        chk("rel_an", {28'd0, an}, 32'hF);
        tick();
        chk("rel_dig0", {28'd0, an}, 32'hE);

        // ---- decimal point on last scorer's digit
        pulse(1'b0, 1'b1, 1'b0);
        wait_an(4'b1101, "wait_dig1_dp");
        for (int k = 0; k < 16; k++) begin
`ifdef SSEG_LAST_POINT_DP_EN
            chk("dp_last", {31'd0, dp}, (an == 4'b1110) ? 32'd0 : 32'd1);
`else
            chk("dp_off", {31'd0, dp}, 32'd1);
`endif
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sseg_score_ctrl.md
Name: sseg_score_ctrl

Overview:
- Score keeper and 4-digit display scanner for the PONG score panel.
- Holds both players' scores and detects game over.
- Time-multiplexes one shared sseg_conv instance across four common-anode digits by driving its 3-bit point code and the active-low anodes.
- Sits between the game logic (point pulses) and the board's 7-segment pins.

Parameters:
REFRESH_DIV, 16'd50000, pclk cycles each digit stays active (>=2)
WIN_SCORE, 3, score that ends the game (1..3)
FLASH_SCANS, 64, full 4-digit scans per half-period of the winner flash (>=1)

Ports:
pclk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
point_l  input  1  one-cycle pulse: left player scored
point_r  input  1  one-cycle pulse: right player scored
new_game  input  1  one-cycle pulse: clear scores, restart
point_code  output  3  code to sseg_conv (0-3 digit, 4 = P, 7 = separator X)
an  output  4  digit anodes, active low, one-cold; an[3] leftmost
dp  output  1  decimal point, active low
score_l  output  2  left score
score_r  output  2  right score
game_over  output  1  high in OVER state

Behaviour:
- Reset (async, rst_n low): an=4'b1111, point_code=3'b111, dp=1, score_l=score_r=0, game_over=0, digit index=0, prescaler=0, flash counters=0, flash phase=on, state=PLAY.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At wrap, digit index advances 0->1->2->3->0.
- Flash scan counter increments when digit index wraps 3->0. At FLASH_SCANS-1 it clears and the flash phase toggles.
- Digit map, indexed by digit index:
  - 3: left score
  - 2: code 7
  - 1: code 7
  - 0: right score
  - Active anode is an[idx] low.
- an and point_code are registered from the digit index and scores. Both change on the same edge, so they are never skewed.
- State machine:
  - PLAY:
    - point_l increments score_l. point_r increments score_r.
    - Simultaneous point_l and point_r: left has priority, point_r is dropped.
    - If the incremented score equals WIN_SCORE, go to OVER on the same edge and latch the winner.
  - OVER:
    - game_over=1; point pulses are ignored.
    - Winner's digit shows code 4 (P). Loser's digit shows its score.
    - During the flash off phase, the winner's digit anode stays high (blank). Other digits are unaffected.
    - Flash phase is forced to on at entry to OVER.
  - new_game in either state:
    - Scores go to 0, state goes to PLAY, the winner is cleared.
    - new_game has priority over a coincident point pulse.
- Latency: score_l/score_r update 1 cycle after the pulse. The display reflects the new value on the first cycle the digit is active after that update, and no later than 1 cycle after the update if the digit is already active.
- Scores saturate at 3. This is unreachable with WIN_SCORE<=3, but required.
- Reset mid-scan returns to digit 0 with all anodes off for the first cycle.

Optional Feature:
SSEG_LAST_POINT_DP_EN
- Defined: dp=0 while the active digit belongs to the player who scored last, otherwise 1. dp is cleared by new_game and reset, is registered alongside an, and is not lit during the flash off phase.
- Undefined: dp is tied to 1 and the last-scorer register is not built.

Test Plan:
- Reset, REFRESH_DIV=4 -> an=1111 for the first cycle, then an sequence 1110,1101,1011,0111 with 4 cycles each. point_code 0,7,7,0.
- Three point_l pulses, 10 cycles apart, WIN_SCORE=3 -> score_l 1,2,3. game_over=1 the cycle after the third pulse. Digit 3 shows code 4. Further point_r is ignored (score_r stays 0).
- OVER with FLASH_SCANS=2 -> an[3] is asserted for 2 full scans, then held high for 2 scans, and this repeats. an[0] keeps scanning normally.
- point_l and point_r in the same cycle from 1-1 -> score_l=2, score_r=1.
- new_game coincident with point_r at 2-2 -> scores 0-0, game_over=0, PLAY.
- rst_n pulsed low mid-scan while OVER -> all outputs at reset values asynchronously, before the next pclk edge.
- With SSEG_LAST_POINT_DP_EN defined and one point_r pulse -> dp=0 only while an=1110.
